// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch controller: FSM encoding, default
// sequential step and the redirect-target alignment helper.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP_DFLT = 4;

  // Redirect targets are forced onto a 4-byte boundary.
  function automatic logic [63:0] align_target(input logic [63:0] tgt);
    return {tgt[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time, holds the
// returned word for downstream, and handles redirects with squash of in-flight data.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = PC_STEP_DFLT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [63:0] InstrPC,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Unconditional,
  input  logic        ALUZero,
  input  logic [63:0] BranchTarget,
  output logic        AlignErr
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  fetch_q, fetch_d;
  logic         squash_q, squash_d;
  logic [31:0]  instr_q, instr_d;
  logic [63:0]  ipc_q, ipc_d;
  logic         align_q, align_d;

  logic         taken;
  logic [63:0]  tgt;
  logic [63:0]  pc_inc;

  assign taken  = (Branch & ALUZero) | Unconditional;
  assign tgt    = align_target(BranchTarget);
  assign pc_inc = pc_q + 64'(PC_STEP);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      fetch_q  <= RESET_PC;
      squash_q <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      align_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fetch_q  <= fetch_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      align_q  <= align_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fetch_d  = fetch_q;
    squash_d = squash_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    align_d  = taken & (BranchTarget[1:0] != 2'b00);

    unique case (state_q)
      ST_IDLE: begin
        fetch_d = pc_q;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // A redirect without ack cannot cancel the bus request, so the stale
        // response is remembered as squashed and discarded when it arrives.
        if (taken) begin
          pc_d = tgt;
          if (ImemAck) begin
            fetch_d  = tgt;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (ImemAck) begin
          if (squash_q) begin
            squash_d = 1'b0;
            fetch_d  = pc_q;
          end else begin
            instr_d = ImemData;
            ipc_d   = fetch_q;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (taken) begin
          pc_d    = tgt;
          fetch_d = tgt;
          state_d = ST_REQ;
        end else if (InstrReady && !Stall) begin
          pc_d    = pc_inc;
          fetch_d = pc_inc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ImemReq    = (state_q == ST_REQ);
  assign ImemAddr   = fetch_q;
  assign InstrValid = (state_q == ST_HOLD);
  assign InstrOut   = instr_q;
  assign InstrPC    = ipc_q;
  assign AlignErr   = align_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios push expected
// hand-offs, a monitor pops and compares on every downstream transfer.
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [63:0] InstrPC;
  logic        Stall;
  logic        Branch;
  logic        Unconditional;
  logic        ALUZero;
  logic [63:0] BranchTarget;
  logic        AlignErr;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    acc_cnt = 0;
  int    ack_delay = 0;
  int    wait_cnt = 0;
  logic  force_ack = 1'b0;

  pc_fetch_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrOut(InstrOut), .InstrPC(InstrPC),
    .Stall(Stall), .Branch(Branch), .Unconditional(Unconditional), .ALUZero(ALUZero),
    .BranchTarget(BranchTarget), .AlignErr(AlignErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] ins);
    xfer_t x;
    x.pc  = pc;
    x.ins = ins;
    exp_q.push_back(x);
  endtask

  // Memory model: answers after ack_delay waiting cycles, data derived from address.
  always @(negedge Clk) begin
    if (force_ack || (ImemReq && wait_cnt >= ack_delay)) begin
      ImemAck  = 1'b1;
      ImemData = 32'hC0DE_0000 | {16'h0, ImemAddr[15:0]};
      wait_cnt = 0;
    end else begin
      ImemAck = 1'b0;
      if (ImemReq) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  // Monitor: a transfer is valid&ready with no stall and no redirect this cycle.
  always @(negedge Clk) begin
    if (Rst_n && InstrValid && InstrReady && !Stall &&
        !((Branch && ALUZero) || Unconditional)) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got pc %h instr %h expected none", InstrPC, InstrOut);
      end else begin
        xfer_t x;
        x = exp_q.pop_front();
        chk("xfer_pc", InstrPC, x.pc);
        chk("xfer_instr", {32'h0, InstrOut}, {32'h0, x.ins});
      end
    end
  end

  task automatic do_reset();
    Rst_n = 1'b0;
    InstrReady = 1'b0; Stall = 1'b0; Branch = 1'b0; Unconditional = 1'b0;
    ALUZero = 1'b0; BranchTarget = '0; ack_delay = 0; force_ack = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req", {63'h0, ImemReq}, 64'h0);
    chk("rst_valid", {63'h0, InstrValid}, 64'h0);
    chk("rst_instr", {32'h0, InstrOut}, 64'h0);
    chk("rst_pc", InstrPC, 64'h0);
    chk("rst_alignerr", {63'h0, AlignErr}, 64'h0);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    acc_cnt = 0;
    Rst_n = 1'b1;
  endtask

  // Wait until every expected transfer has been seen, then block further hand-offs.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    InstrReady = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ImemAck = 1'b0;
    ImemData = '0;

    // Zero-wait stream: 0,4,8,C accepted within 9 edges of reset release.
    do_reset();
    InstrReady = 1'b1;
    push(64'h0, 32'hC0DE_0000); push(64'h4, 32'hC0DE_0004);
    push(64'h8, 32'hC0DE_0008); push(64'hC, 32'hC0DE_000C);
    repeat (9) @(posedge Clk);
    #1;
    InstrReady = 1'b0;
    chk("stream_count", 64'(acc_cnt), 64'd4);

    // Delayed ack: request for 0x8 held stable while waiting.
    do_reset();
    InstrReady = 1'b1;
    push(64'h0, 32'hC0DE_0000); push(64'h4, 32'hC0DE_0004); push(64'h8, 32'hC0DE_0008);
    repeat (5) @(posedge Clk);
    #1;
    ack_delay = 3;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {63'h0, ImemReq}, 64'h1);
      chk("wait_addr", ImemAddr, 64'h8);
      @(posedge Clk);
      #1;
    end
    drain(40);

    // Unconditional redirect while 0x8 is outstanding: its data is dropped.
    do_reset();
    InstrReady = 1'b1;
    push(64'h0, 32'hC0DE_0000); push(64'h4, 32'hC0DE_0004);
    repeat (5) @(posedge Clk);
    #1;
    ack_delay = 3;
    @(posedge Clk);
    #1;
    Unconditional = 1'b1; BranchTarget = 64'h100;
    @(posedge Clk);
    #1;
    Unconditional = 1'b0; ack_delay = 0;
    chk("squash_addr_kept", ImemAddr, 64'h8);
    push(64'h100, 32'hC0DE_0100);
    drain(40);

    // Taken branch in HOLD beats InstrReady; ALUZero=0 does not redirect; wrap at 2^64.
    do_reset();
    InstrReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Branch = 1'b1; ALUZero = 1'b1; BranchTarget = 64'h40;
    @(posedge Clk);
    #1;
    Branch = 1'b0; ALUZero = 1'b0;
    chk("br_fetch", ImemAddr, 64'h40);
    chk("br_flush_valid", {63'h0, InstrValid}, 64'h0);
    push(64'h40, 32'hC0DE_0040);
    drain(40);
    @(posedge Clk);
    #1;
    push(64'h44, 32'hC0DE_0044);
    Branch = 1'b1; ALUZero = 1'b0; BranchTarget = 64'h80; InstrReady = 1'b1;
    @(posedge Clk);
    #1;
    Branch = 1'b0; InstrReady = 1'b0;
    chk("notaken_fetch", ImemAddr, 64'h48);
    @(posedge Clk);
    #1;
    Unconditional = 1'b1; BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
    push(64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DE_FFFC);
    push(64'h0, 32'hC0DE_0000);
    @(posedge Clk);
    #1;
    Unconditional = 1'b0;
    chk("wrap_fetch", ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    InstrReady = 1'b1;
    drain(40);

    // Stall holds the instruction; misaligned redirect aligns and pulses AlignErr.
    do_reset();
    push(64'h0, 32'hC0DE_0000);
    repeat (2) @(posedge Clk);
    #1;
    Stall = 1'b1; InstrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      chk("stall_valid", {63'h0, InstrValid}, 64'h1);
      chk("stall_pc", InstrPC, 64'h0);
    end
    Stall = 1'b0; InstrReady = 1'b0;
    Unconditional = 1'b1; BranchTarget = 64'h102;
    exp_q.delete();
    push(64'h100, 32'hC0DE_0100);
    @(posedge Clk);
    #1;
    Unconditional = 1'b0;
    chk("align_pulse", {63'h0, AlignErr}, 64'h1);
    chk("align_fetch", ImemAddr, 64'h100);
    @(posedge Clk);
    #1;
    chk("align_pulse_end", {63'h0, AlignErr}, 64'h0);
    InstrReady = 1'b1;
    drain(40);

    // Reset mid-request abandons it; an ack seen in IDLE is ignored.
    do_reset();
    ack_delay = 5;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("midrst_req", {63'h0, ImemReq}, 64'h0);
    Rst_n = 1'b1; force_ack = 1'b1; ack_delay = 0;
    @(posedge Clk);
    #1;
    force_ack = 1'b0;
    chk("idle_ack_req", {63'h0, ImemReq}, 64'h1);
    chk("idle_ack_valid", {63'h0, InstrValid}, 64'h0);
    chk("idle_ack_addr", ImemAddr, 64'h0);
    InstrReady = 1'b1;
    push(64'h0, 32'hC0DE_0000);
    drain(40);

    chk("final_sb_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-003 Port Clk, input, 1: single clock; all state updates on posedge Clk.
REQ-004 Port Rst_n, input, 1: synchronous reset, active-low, sampled on posedge Clk.
REQ-005 Port ImemReq, output, 1: instruction-memory request, held until ImemAck.
REQ-006 Port ImemAddr, output, 64: fetch address; stable while ImemReq=1.
REQ-007 Port ImemAck, input, 1: memory response strobe; ImemData valid this cycle.
REQ-008 Port ImemData, input, 32: fetched instruction word.
REQ-009 Port InstrValid, output, 1: InstrOut/InstrPC valid to downstream.
REQ-010 Port InstrReady, input, 1: downstream accepts when InstrValid and InstrReady are both 1.
REQ-011 Port InstrOut, output, 32: held instruction.
REQ-012 Port InstrPC, output, 64: address InstrOut was fetched from.
REQ-013 Port Stall, input, 1: freezes hand-off and PC advance; an outstanding request still completes.
REQ-014 Port Branch, Unconditional, ALUZero, inputs, 1 each: redirect controls.
REQ-015 Port BranchTarget, input, 64: redirect address.
REQ-016 Port AlignErr, output, 1: one-cycle pulse on misaligned redirect target.

Function
REQ-017 Taken SHALL equal (Branch AND ALUZero) OR Unconditional, evaluated each cycle.
REQ-018 FSM states SHALL be IDLE, REQ, HOLD; IDLE is entered only from reset.
REQ-019 IDLE: next cycle SHALL set FetchAddr <= PC and go to REQ.
REQ-020 REQ: ImemReq=1 and ImemAddr=FetchAddr; stay in REQ until ImemAck=1.
REQ-021 REQ with ImemAck=1 and Squash=0: latch ImemData into InstrOut and FetchAddr into InstrPC; go to HOLD.
REQ-022 REQ with ImemAck=1 and Squash=1: discard data, clear Squash, set FetchAddr <= PC, remain in REQ with ImemReq=1 the next cycle.
REQ-023 HOLD: InstrValid=1; on InstrReady=1 and Stall=0, PC <= PC+PC_STEP, FetchAddr <= PC+PC_STEP, go to REQ.
REQ-024 HOLD with Stall=1: InstrValid SHALL stay 1 and no transfer SHALL occur; PC and outputs hold.
REQ-025 Taken=1 in any non-IDLE state: PC <= {BranchTarget[63:2],2'b00}; redirect SHALL take priority over sequential advance.
REQ-026 Taken in REQ without ImemAck: set Squash; FetchAddr unchanged until the ack completes.
REQ-027 Taken in REQ on the ack cycle: drop data, FetchAddr <= target, stay in REQ; Squash stays 0.
REQ-028 Taken in HOLD: InstrValid <= 0 (held instruction flushed, no transfer even if InstrReady=1), FetchAddr <= target, go to REQ.
REQ-029 AlignErr SHALL pulse 1 cycle (registered) when Taken=1 and BranchTarget[1:0] != 0.
REQ-030 PC arithmetic SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.
REQ-031 Max throughput: one instruction per 2 cycles with zero-wait memory (REQ-ack, HOLD-accept).

Reset
REQ-032 Rst_n=0 at posedge Clk SHALL set state IDLE, PC=FetchAddr=RESET_PC, Squash=0, InstrOut=0, InstrPC=0, InstrValid=0, ImemReq=0, AlignErr=0.
REQ-033 Reset mid-request SHALL abandon the outstanding request; an ImemAck arriving in IDLE SHALL be ignored.

Structure
REQ-034 State encoding and PC_STEP SHALL reside in shared package pc_pkg, reused by the PC datapath.
REQ-035 No sub-module; the FSM, PC/FetchAddr registers and output registers are in one module.

Verification
REQ-036 Reset release, ImemAck 1 cycle after each request, InstrReady=1 -> InstrPC sequence 0,4,8,C, one per 2 cycles.
REQ-037 Ack delayed 3 cycles -> ImemReq/ImemAddr=0x8 held stable 3 cycles; InstrOut matches ImemData.
REQ-038 Unconditional=1, target 0x100, while waiting for ack of 0x8 -> 0x8 data dropped, next InstrPC=0x100.
REQ-039 Branch=1, ALUZero=1, target 0x40 in HOLD with InstrReady=1 -> no transfer, next fetch 0x40; ALUZero=0 -> no redirect.
REQ-040 Stall=1 for 5 cycles in HOLD -> InstrValid=1, InstrPC constant; target 0x102 -> fetch 0x100, AlignErr one-cycle pulse.
